// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 request arbiter: state encoding, owner
// encoding and default address/line widths.
package l2_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 27;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/l2_arb_req_slot.sv
// One-deep pending slot per requester: captures a miss address and holds it
// until the arbiter clears the slot after the fill.
module l2_arb_req_slot
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_clear,
    output logic              o_pending,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic              w_accept;

    // A new request is taken only into an empty slot, or one being freed this cycle.
    assign w_accept = i_req_valid & (~r_pending | i_clear);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_addr    <= i_req_addr;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_addr    = r_addr;

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates I-side and D-side line misses onto a single L2 request port,
// one outstanding transaction at a time, round-robin on ties.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ_VALID,
    input  logic [ADDR_W-1:0] I_REQ_ADDR,
    output logic              I_RESP_VALID,
    output logic [LINE_W-1:0] I_RESP_DATA,
    input  logic              D_REQ_VALID,
    input  logic [ADDR_W-1:0] D_REQ_ADDR,
    output logic              D_RESP_VALID,
    output logic [LINE_W-1:0] D_RESP_DATA,
    output logic              L2_REQ_VALID,
    output logic [ADDR_W-1:0] L2_REQ_ADDR,
    input  logic              L2_REQ_READY,
    input  logic              L2_RESP_VALID,
    input  logic [LINE_W-1:0] L2_RESP_DATA,
    output logic              BUSY,
    output logic              OWNER
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              w_grant;
    logic              w_fill;

    logic              w_i_pend;
    logic              w_d_pend;
    logic [ADDR_W-1:0] w_i_addr;
    logic [ADDR_W-1:0] w_d_addr;
    logic              w_i_cand;
    logic              w_d_cand;
    logic              w_grant_d;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_i_clear;
    logic              w_d_clear;

    logic              r_prio;
    logic              r_owner;
    logic              r_busy;
    logic              r_l2_req_valid;
    logic [ADDR_W-1:0] r_l2_req_addr;
    logic              r_i_resp_valid;
    logic [LINE_W-1:0] r_i_resp_data;
    logic              r_d_resp_valid;
    logic [LINE_W-1:0] r_d_resp_data;

    assign w_i_clear = w_fill & (r_owner == OWNER_I);
    assign w_d_clear = w_fill & (r_owner == OWNER_D);

    l2_arb_req_slot #(.ADDR_W(ADDR_W)) u_i_slot (
        .CLK         (CLK),
        .RST         (RST),
        .i_req_valid (I_REQ_VALID),
        .i_req_addr  (I_REQ_ADDR),
        .i_clear     (w_i_clear),
        .o_pending   (w_i_pend),
        .o_addr      (w_i_addr)
    );

    l2_arb_req_slot #(.ADDR_W(ADDR_W)) u_d_slot (
        .CLK         (CLK),
        .RST         (RST),
        .i_req_valid (D_REQ_VALID),
        .i_req_addr  (D_REQ_ADDR),
        .i_clear     (w_d_clear),
        .o_pending   (w_d_pend),
        .o_addr      (w_d_addr)
    );

    // Candidates include same-cycle pulses so an idle arbiter issues with one cycle latency.
    assign w_i_cand     = w_i_pend | I_REQ_VALID;
    assign w_d_cand     = w_d_pend | D_REQ_VALID;
    assign w_grant_d    = w_d_cand & (~w_i_cand | r_prio);
    assign w_grant_addr = w_grant_d ? (w_d_pend ? w_d_addr : D_REQ_ADDR)
                                    : (w_i_pend ? w_i_addr : I_REQ_ADDR);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_i_cand | w_d_cand) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (L2_REQ_READY) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (L2_RESP_VALID) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs; r_prio names the side that wins the next tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio         <= OWNER_I;
            r_owner        <= OWNER_I;
            r_busy         <= 1'b0;
            r_l2_req_valid <= 1'b0;
            r_l2_req_addr  <= '0;
            r_i_resp_valid <= 1'b0;
            r_i_resp_data  <= '0;
            r_d_resp_valid <= 1'b0;
            r_d_resp_data  <= '0;
        end else begin
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_l2_req_valid <= (w_state_nxt == ST_ISSUE);
            r_i_resp_valid <= w_i_clear;
            r_d_resp_valid <= w_d_clear;
            if (w_grant) begin
                r_owner       <= w_grant_d;
                r_l2_req_addr <= w_grant_addr;
            end
            if (w_fill) r_prio <= ~r_owner;
            if (w_i_clear) r_i_resp_data <= L2_RESP_DATA;
            if (w_d_clear) r_d_resp_data <= L2_RESP_DATA;
        end
    end

    assign I_RESP_VALID = r_i_resp_valid;
    assign I_RESP_DATA  = r_i_resp_data;
    assign D_RESP_VALID = r_d_resp_valid;
    assign D_RESP_DATA  = r_d_resp_data;
    assign L2_REQ_VALID = r_l2_req_valid;
    assign L2_REQ_ADDR  = r_l2_req_addr;
    assign BUSY         = r_busy;
    assign OWNER        = r_owner;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: a vector table of miss patterns
// plus directed sequences for drop, set-over-clear and reset-in-WAIT cases.
module tb_l2_req_arbiter;
    import l2_arb_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;
    localparam int unsigned LW = LINE_W_DEF;

    logic          CLK = 1'b0;
    logic          RST;
    logic          I_REQ_VALID, D_REQ_VALID;
    logic [AW-1:0] I_REQ_ADDR, D_REQ_ADDR;
    logic          I_RESP_VALID, D_RESP_VALID;
    logic [LW-1:0] I_RESP_DATA, D_RESP_DATA;
    logic          L2_REQ_VALID, L2_REQ_READY, L2_RESP_VALID;
    logic [AW-1:0] L2_REQ_ADDR;
    logic [LW-1:0] L2_RESP_DATA;
    logic          BUSY, OWNER;

    l2_req_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ_VALID(I_REQ_VALID), .I_REQ_ADDR(I_REQ_ADDR),
        .I_RESP_VALID(I_RESP_VALID), .I_RESP_DATA(I_RESP_DATA),
        .D_REQ_VALID(D_REQ_VALID), .D_REQ_ADDR(D_REQ_ADDR),
        .D_RESP_VALID(D_RESP_VALID), .D_RESP_DATA(D_RESP_DATA),
        .L2_REQ_VALID(L2_REQ_VALID), .L2_REQ_ADDR(L2_REQ_ADDR),
        .L2_REQ_READY(L2_REQ_READY), .L2_RESP_VALID(L2_RESP_VALID),
        .L2_RESP_DATA(L2_RESP_DATA), .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          iv;
        logic [AW-1:0] ia;
        logic          dv;
        logic [AW-1:0] da;
        int unsigned   dly;
        logic          first_d;
    } vec_t;

    typedef struct {
        logic          side;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic side, input logic [AW-1:0] addr);
        exp_t e;
        e.side = side;
        e.addr = addr;
        e.data = {8{32'hA5A5_A5A5 ^ 32'(n_txn)}};
        n_txn++;
        exp_q.push_back(e);
    endtask

    // Current cycle must show L2_REQ_VALID; completes handshake and fill.
    task automatic hs_fill(input int unsigned dly, input logic inj, input logic [AW-1:0] inj_addr);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", LW'(1), LW'(0));
            return;
        end
        e = exp_q.pop_front();
        for (int c = 0; c < int'(dly); c++) begin
            L2_REQ_READY = 1'b0;
            check("hold_valid", LW'(L2_REQ_VALID), LW'(1));
            check("hold_addr", LW'(L2_REQ_ADDR), LW'(e.addr));
            tick();
        end
        L2_REQ_READY = 1'b1;
        check("req_valid", LW'(L2_REQ_VALID), LW'(1));
        check("req_addr", LW'(L2_REQ_ADDR), LW'(e.addr));
        check("owner", LW'(OWNER), LW'(e.side));
        check("busy_issue", LW'(BUSY), LW'(1));
        tick();
        L2_REQ_READY = 1'b0;
        check("req_drop", LW'(L2_REQ_VALID), LW'(0));
        check("busy_wait", LW'(BUSY), LW'(1));
        tick();
        L2_RESP_VALID = 1'b1;
        L2_RESP_DATA  = e.data;
        I_REQ_VALID   = inj;
        I_REQ_ADDR    = inj_addr;
        tick();
        L2_RESP_VALID = 1'b0;
        I_REQ_VALID   = 1'b0;
        check("resp_own", LW'(e.side ? D_RESP_VALID : I_RESP_VALID), LW'(1));
        check("resp_other", LW'(e.side ? I_RESP_VALID : D_RESP_VALID), LW'(0));
        check("resp_data", e.side ? D_RESP_DATA : I_RESP_DATA, e.data);
    endtask

    // Expects a request one cycle after the current one.
    task automatic serve(input int unsigned dly);
        tick();
        I_REQ_VALID = 1'b0;
        D_REQ_VALID = 1'b0;
        check("resp_pulse_end", LW'({I_RESP_VALID, D_RESP_VALID}), LW'(0));
        check("req_latency", LW'(L2_REQ_VALID), LW'(1));
        hs_fill(dly, 1'b0, '0);
    endtask

    task automatic idle_check();
        tick();
        check("idle_busy", LW'(BUSY), LW'(0));
        check("idle_req", LW'(L2_REQ_VALID), LW'(0));
        check("idle_resp", LW'({I_RESP_VALID, D_RESP_VALID}), LW'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        I_REQ_VALID = v.iv;
        I_REQ_ADDR  = v.ia;
        D_REQ_VALID = v.dv;
        D_REQ_ADDR  = v.da;
        if (v.first_d) begin
            if (v.dv) push(OWNER_D, v.da);
            if (v.iv) push(OWNER_I, v.ia);
        end else begin
            if (v.iv) push(OWNER_I, v.ia);
            if (v.dv) push(OWNER_D, v.da);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) serve(v.dly);
        idle_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 27'h0001234, 1'b0, 27'h0,       0, 1'b0};
        vecs[1] = '{1'b0, 27'h0,       1'b1, 27'h000ABCD, 2, 1'b1};
        vecs[2] = '{1'b1, 27'h0000010, 1'b1, 27'h0000020, 0, 1'b0};
        vecs[3] = '{1'b1, 27'h0000030, 1'b1, 27'h0000040, 4, 1'b0};
        vecs[4] = '{1'b1, 27'h0000077, 1'b0, 27'h0,       1, 1'b0};
        vecs[5] = '{1'b1, 27'h0000088, 1'b1, 27'h0000099, 0, 1'b1};
        vecs[6] = '{1'b1, 27'h7FFFFFF, 1'b1, 27'h0000001, 1, 1'b1};

        RST = 1'b1;
        I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
        D_REQ_VALID = 1'b0; D_REQ_ADDR = '0;
        L2_REQ_READY = 1'b0; L2_RESP_VALID = 1'b0; L2_RESP_DATA = '0;
        repeat (3) tick();
        RST = 1'b0;
        check("rst_outputs", LW'({L2_REQ_VALID, L2_REQ_ADDR, I_RESP_VALID, D_RESP_VALID, BUSY, OWNER}), LW'(0));
        check("rst_i_data", I_RESP_DATA, '0);
        check("rst_d_data", D_RESP_DATA, '0);
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Owner re-requests in its fill cycle: the new address must still be issued.
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 27'h0000123;
        push(OWNER_I, 27'h0000123);
        push(OWNER_I, 27'h0000456);
        tick();
        I_REQ_VALID = 1'b0;
        check("sw_req", LW'(L2_REQ_VALID), LW'(1));
        hs_fill(0, 1'b1, 27'h0000456);
        serve(0);
        idle_check();

        // Stray fill in IDLE, then a duplicate I pulse while I waits behind D.
        L2_RESP_VALID = 1'b1; L2_RESP_DATA = {LW{1'b1}};
        tick();
        L2_RESP_VALID = 1'b0;
        check("stray_resp", LW'({I_RESP_VALID, D_RESP_VALID, BUSY}), LW'(0));
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 27'h0000300;
        push(OWNER_D, 27'h0000300);
        push(OWNER_I, 27'h0000111);
        tick();
        D_REQ_VALID = 1'b0;
        check("dup_d_req", LW'(L2_REQ_VALID), LW'(1));
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 27'h0000111;
        tick();
        I_REQ_ADDR = 27'h0000222;
        tick();
        I_REQ_VALID = 1'b0;
        hs_fill(0, 1'b0, '0);
        serve(0);
        idle_check();

        // Reset while waiting for a D fill; the late fill must be ignored.
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 27'h00005A5;
        tick();
        D_REQ_VALID = 1'b0;
        L2_REQ_READY = 1'b1;
        check("rw_req", LW'(L2_REQ_VALID), LW'(1));
        tick();
        L2_REQ_READY = 1'b0;
        check("rw_wait", LW'({BUSY, OWNER, L2_REQ_VALID}), LW'(3'b110));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        L2_RESP_VALID = 1'b1; L2_RESP_DATA = {8{32'hDEAD_BEEF}};
        tick();
        L2_RESP_VALID = 1'b0;
        check("rw_outputs", LW'({L2_REQ_VALID, L2_REQ_ADDR, I_RESP_VALID, D_RESP_VALID, BUSY, OWNER}), LW'(0));
        check("rw_i_data", I_RESP_DATA, '0);
        check("rw_d_data", D_RESP_DATA, '0);
        tick();
        check("rw_quiet", LW'({L2_REQ_VALID, I_RESP_VALID, D_RESP_VALID, BUSY}), LW'(0));
        check("rw_sb_empty", LW'(exp_q.size()), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter.md
L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 27: line-address width (byte address minus 5 offset bits).
REQ-002 Parameter LINE_W, default 256: cache-line data width (8 x 32-bit words).
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 I_REQ_VALID  in  1  I-side miss request pulse.
REQ-006 I_REQ_ADDR  in  ADDR_W  I-side line address, sampled with I_REQ_VALID.
REQ-007 I_RESP_VALID  out  1  one-cycle I-side fill pulse.
REQ-008 I_RESP_DATA  out  LINE_W  I-side fill line.
REQ-009 D_REQ_VALID, D_REQ_ADDR, D_RESP_VALID, D_RESP_DATA: D-side ports, same directions, widths and meanings as the I-side ports.
REQ-010 L2_REQ_VALID  out  1  request to L2, held until accepted.
REQ-011 L2_REQ_ADDR  out  ADDR_W  line address to L2, stable while L2_REQ_VALID is high.
REQ-012 L2_REQ_READY  in  1  L2 accepts the request when high together with L2_REQ_VALID.
REQ-013 L2_RESP_VALID  in  1  L2 fill-data pulse.
REQ-014 L2_RESP_DATA  in  LINE_W  L2 fill line.
REQ-015 BUSY  out  1  high in ISSUE and WAIT.
REQ-016 OWNER  out  1  current or last grant: 0 = I, 1 = D.

Function
REQ-017 Each side SHALL have one pending slot. A REQ_VALID pulse sets pending and captures the address.
REQ-018 A REQ_VALID pulse on a side whose slot is already pending SHALL be dropped; the captured address is unchanged.
REQ-019 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-020 IDLE: candidates are pending slots plus REQ_VALID pulses arriving this cycle (bypass).
- If any candidate exists: grant one, register its address into L2_REQ_ADDR, set OWNER, go to ISSUE.
- Result: L2_REQ_VALID is high in cycle N+1 for a pulse in cycle N.
REQ-021 Arbitration SHALL be round-robin: the side not granted last wins a tie. After reset, I wins the first tie.
REQ-022 ISSUE: hold L2_REQ_VALID=1 and L2_REQ_ADDR until L2_REQ_READY=1, then go to WAIT. L2_REQ_VALID is low from the next cycle.
REQ-023 WAIT: on L2_RESP_VALID, register L2_RESP_DATA into the owner's RESP_DATA, pulse the owner's RESP_VALID for exactly 1 cycle (cycle after L2_RESP_VALID), clear the owner's pending slot, update the round-robin pointer, return to IDLE.
REQ-024 L2_RESP_VALID in IDLE or ISSUE SHALL be ignored.
REQ-025 Only one L2 transaction SHALL be outstanding at any time.
REQ-026 Simultaneous events:
- A REQ_VALID on the owner side in the same cycle as its pending-clear SHALL set pending with the new address (set wins over clear).
- A non-owner request arriving during ISSUE or WAIT SHALL be held pending.
REQ-027 The non-owner RESP_VALID SHALL stay 0. RESP_DATA SHALL hold its last value between fills.
REQ-028 Back-to-back service: a pending non-owner request SHALL be granted in the first IDLE cycle after the fill, so the next L2_REQ_VALID is high 2 cycles after L2_RESP_VALID.

Reset
REQ-029 RST SHALL drive state=IDLE, both pending=0, round-robin pointer=I-priority and OWNER=0.
REQ-030 RST SHALL drive L2_REQ_VALID=0, L2_REQ_ADDR=0, I/D_RESP_VALID=0 and I/D_RESP_DATA=0.
REQ-031 RST during ISSUE or WAIT SHALL abandon the transaction. A late L2_RESP_VALID SHALL then be ignored per REQ-024.

Structure
REQ-032 Package l2_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the owner encoding (I=0, D=1) and the ADDR_W/LINE_W defaults.
REQ-033 The pending slot (flag plus address capture, REQ-017/018/026) SHALL be sub-module l2_arb_req_slot, instantiated twice.

Verification
REQ-034 Single I miss: I_REQ_VALID at cycle 5, addr 0x0001234; L2_REQ_READY=1; L2_RESP_VALID at cycle 10, data 0xA5..A5 -> L2_REQ_VALID high cycle 6 only, I_RESP_VALID high cycle 11 with 0xA5..A5, D_RESP_VALID stays 0.
REQ-035 Simultaneous I and D pulses (0x10, 0x20) after reset -> I granted first (L2_REQ_ADDR=0x10); D granted (0x20) 2 cycles after I's fill; the next simultaneous pair is granted in the same order (I after D), exercising round-robin.
REQ-036 L2_REQ_READY low for 4 cycles -> L2_REQ_VALID/ADDR held stable 5 cycles, one handshake only.
REQ-037 Stray L2_RESP_VALID in IDLE, then a duplicate I_REQ_VALID while I is pending -> no RESP_VALID, the second address is dropped, and one L2 request carries the first address.
REQ-038 RST asserted in WAIT, then L2_RESP_VALID the next cycle -> all outputs 0, state IDLE, no RESP_VALID.
